frac_clken_gen: RTL
===================

FRAC_CLKEN_GEN -- requirements
Module: frac_clken_gen

Interface
REQ-001 SHALL provide parameter NUM_CH, default 8, number of independent clock-enable channels (1..16).
REQ-002 SHALL provide parameter ACC_W, default 16, width of numerator, denominator and accumulator per channel.
REQ-003 SHALL provide parameter LOCK_DELAY, default 16, settle count in refclk cycles before locked asserts (1..65535).
REQ-004 SHALL provide parameter DEF_NUM, default all-ones-LSB (1 per channel), packed NUM_CH*ACC_W reset numerators.
REQ-005 SHALL provide parameter DEF_DEN, default 8 per channel, packed NUM_CH*ACC_W reset denominators.
REQ-006 refclk  input  1  sole clock; all logic on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 cfg_we  input  1  one-cycle write strobe for channel configuration.
REQ-009 cfg_ch  input  4  channel index for write.
REQ-010 cfg_num  input  ACC_W  numerator to load.
REQ-011 cfg_den  input  ACC_W  denominator to load.
REQ-012 ce  output  NUM_CH  registered one-cycle clock-enable pulses, bit i = channel i.
REQ-013 locked  output  1  high when all channels have run stable configuration for LOCK_DELAY cycles.

Function
REQ-014 Each channel SHALL compute s = acc + num (ACC_W+1 bits); if s >= den then acc <= s - den and ce[i] <= 1, else acc <= s and ce[i] <= 0.
REQ-015 Average ce rate SHALL equal f_refclk * num/den exactly, with no cumulative drift.
REQ-016 Channel with num = 0 or den = 0 SHALL be disabled: ce[i] held 0, acc held 0.
REQ-017 Channel with num >= den (den != 0) SHALL assert ce[i] every cycle.
REQ-018 cfg_we with cfg_ch < NUM_CH SHALL load num/den of that channel and clear its acc and ce in the following cycle; new ratio takes effect on the cycle after the write.
REQ-019 cfg_we with cfg_ch >= NUM_CH SHALL be ignored entirely (no lock drop).
REQ-020 Lock counter SHALL count up from 0 each cycle; locked <= 1 when count reaches LOCK_DELAY; count saturates.
REQ-021 Any accepted write SHALL clear the lock counter and deassert locked the next cycle; back-to-back writes restart the count each time.
REQ-022 ce SHALL be forced to 0 on all channels while locked = 0 (accumulators still advance).

Reset
REQ-023 On rst high: num/den <= DEF_NUM/DEF_DEN, acc <= 0, ce <= 0, lock count <= 0, locked <= 0, asynchronously.
REQ-024 Reset asserted mid-operation SHALL discard pending writes and restart lock sequence after release.

Configuration
REQ-025 Macro FRAC_CLKEN_SQUARE_EN defined: add output sq (NUM_CH) where sq[i] toggles on every ce[i] pulse, reset 0, held 0 while channel disabled or locked = 0.
REQ-026 Macro undefined: no sq port, no toggle flops.

Structure
REQ-027 Package frac_clken_pkg SHALL hold ACC_W default, max channel count, channel-index width and the channel config struct (num, den).
REQ-028 Per-channel accumulator SHALL be sub-module frac_clken_ch, instantiated NUM_CH times via generate.

Verification
REQ-029 Reset release, defaults num=1 den=8: locked rises at cycle 16, then ce[0] pulses every 8 cycles (10 MHz at 80 MHz refclk).
REQ-030 Write ch2 num=1 den=26: locked drops next cycle, returns after 16 cycles; ce[2] period exactly 26 cycles (3.076923 MHz).
REQ-031 Write ch1 num=3 den=8: exactly 3 pulses per every 8-cycle window, pattern repeats every 8 cycles over 10000 cycles.
REQ-032 Write ch3 num=0 or den=0 -> ce[3] stays 0; write ch4 num=9 den=8 -> ce[4] high every cycle once locked.
REQ-033 Write cfg_ch=15 with NUM_CH=8 -> no state change, locked stays high; rst pulse mid-run -> all outputs 0 immediately, lock resequenced.
REQ-034 With FRAC_CLKEN_SQUARE_EN, num=1 den=8 -> sq[0] period 16 cycles, 50% duty.

Source files
------------

// File: rtl/frac_clken_pkg.sv
// Shared constants and types for the fractional clock-enable generator.
package frac_clken_pkg;

  localparam int ACC_W_DEF = 16;
  localparam int MAX_CH    = 16;
  localparam int CH_IDX_W  = 4;

  typedef struct packed {
    logic [ACC_W_DEF-1:0] num;
    logic [ACC_W_DEF-1:0] den;
  } ch_cfg_t;

endpackage

// File: rtl/frac_clken_ch.sv
// One fractional-N accumulator channel: emits ce at the average rate num/den.
// Optional FRAC_CLKEN_SQUARE_EN adds a square-wave output toggled by each ce.
module frac_clken_ch
  import frac_clken_pkg::*;
#(
  parameter int               ACC_W   = ACC_W_DEF,
  parameter logic [ACC_W-1:0] RST_NUM = ACC_W'(1),
  parameter logic [ACC_W-1:0] RST_DEN = ACC_W'(8)
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             ld,
  input  logic [ACC_W-1:0] ld_num,
  input  logic [ACC_W-1:0] ld_den,
  input  logic             lock_en,
`ifdef FRAC_CLKEN_SQUARE_EN
  output logic             sq,
`endif
  output logic             ce
);

  logic [ACC_W-1:0] num_q, num_d;
  logic [ACC_W-1:0] den_q, den_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ce_q, ce_d;
  logic [ACC_W:0]   sum_s;
  logic [ACC_W:0]   rem_s;
  logic             en_s;
  logic             hit_s;

  // Next-state: load new ratio, hold disabled channel idle, or advance the accumulator.
  always_comb begin
    num_d = num_q;
    den_d = den_q;
    acc_d = acc_q;
    hit_s = 1'b0;
    sum_s = {1'b0, acc_q} + {1'b0, num_q};
    rem_s = sum_s - {1'b0, den_q};
    en_s  = (num_q != '0) && (den_q != '0);
    if (ld) begin
      num_d = ld_num;
      den_d = ld_den;
      acc_d = '0;
    end else if (!en_s) begin
      acc_d = '0;
    end else if (sum_s >= {1'b0, den_q}) begin
      acc_d = rem_s[ACC_W-1:0];
      hit_s = 1'b1;
    end else begin
      acc_d = sum_s[ACC_W-1:0];
    end
    // lock_en is already low on a load cycle, so this also clears ce on load.
    ce_d = hit_s && lock_en;
  end

  // Channel state registers.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      num_q <= RST_NUM;
      den_q <= RST_DEN;
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      num_q <= num_d;
      den_q <= den_d;
      acc_q <= acc_d;
      ce_q  <= ce_d;
    end
  end

  assign ce = ce_q;

`ifdef FRAC_CLKEN_SQUARE_EN
  logic sq_q, sq_d;

  // Square wave toggles per ce pulse, parked low when idle or unlocked.
  always_comb begin
    if (ld || !en_s || !lock_en) begin
      sq_d = 1'b0;
    end else if (ce_d) begin
      sq_d = ~sq_q;
    end else begin
      sq_d = sq_q;
    end
  end

  // Square wave register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sq_q <= 1'b0;
    end else begin
      sq_q <= sq_d;
    end
  end

  assign sq = sq_q;
`endif

endmodule

// File: rtl/frac_clken_gen.sv
// Multi-channel fractional clock-enable generator with a shared lock sequencer.
// Define FRAC_CLKEN_SQUARE_EN to add the per-channel square-wave output sq.
module frac_clken_gen
  import frac_clken_pkg::*;
#(
  parameter int                        NUM_CH     = 8,
  parameter int                        ACC_W      = ACC_W_DEF,
  parameter int                        LOCK_DELAY = 16,
  parameter logic [NUM_CH*ACC_W-1:0]   DEF_NUM    = {NUM_CH{ACC_W'(1)}},
  parameter logic [NUM_CH*ACC_W-1:0]   DEF_DEN    = {NUM_CH{ACC_W'(8)}}
) (
  input  logic                refclk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [ACC_W-1:0]    cfg_num,
  input  logic [ACC_W-1:0]    cfg_den,
`ifdef FRAC_CLKEN_SQUARE_EN
  output logic [NUM_CH-1:0]   sq,
`endif
  output logic [NUM_CH-1:0]   ce,
  output logic                locked
);

  localparam int              IDX_W1   = CH_IDX_W + 1;
  localparam logic [15:0]     LOCK_CNT = 16'(LOCK_DELAY);
  localparam logic [IDX_W1-1:0] NUM_CH_W = IDX_W1'(NUM_CH);

  logic [15:0] lock_cnt_q, lock_cnt_d;
  logic        locked_q, locked_d;
  logic        wr_ok_s;

  // Lock sequencer: restart on any accepted write, saturate at LOCK_DELAY.
  always_comb begin
    wr_ok_s = cfg_we && ({1'b0, cfg_ch} < NUM_CH_W);
    if (wr_ok_s) begin
      lock_cnt_d = 16'd0;
    end else if (lock_cnt_q < LOCK_CNT) begin
      lock_cnt_d = lock_cnt_q + 16'd1;
    end else begin
      lock_cnt_d = lock_cnt_q;
    end
    locked_d = (lock_cnt_d == LOCK_CNT);
  end

  // Lock sequencer registers.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_cnt_q <= 16'd0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign locked = locked_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CH_IDX_W-1:0] IDX = CH_IDX_W'(i);
    logic ld_s;
    assign ld_s = wr_ok_s && (cfg_ch == IDX);

    frac_clken_ch #(
      .ACC_W   (ACC_W),
      .RST_NUM (DEF_NUM[i*ACC_W +: ACC_W]),
      .RST_DEN (DEF_DEN[i*ACC_W +: ACC_W])
    ) u_ch (
      .refclk  (refclk),
      .rst     (rst),
      .ld      (ld_s),
      .ld_num  (cfg_num),
      .ld_den  (cfg_den),
      .lock_en (locked_d),
`ifdef FRAC_CLKEN_SQUARE_EN
      .sq      (sq[i]),
`endif
      .ce      (ce[i])
    );
  end

endmodule
